disp_arbiter: RTL and testbench

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_arbiter.sv | 173 +++++++++++++++++
 tb/tb_disp_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_arbiter
// Description : Round-robin arbiter that gives one of three requesters the
//               display and forwards that requester's 16-bit hex value to the
//               display driver. A new owner keeps the display for at least
//               HOLD_CYCLES clock cycles. After that it can be pre-empted by
//               another requester, or it releases the display when it drops
//               its request.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset
//               req[2:0] - per-requester display request
//               data0..2 - requester hex values (digit 3 = [15:12])
//               grant    - registered one-hot owner, 000 when there is no owner
//               data_out - registered value sent to the display driver
//               blank    - registered, 1 when there is no owner
// Revision    : 1.0 - initial release
// ============================================================================
module disp_arbiter #(
  parameter int HOLD_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [15:0] data_out,
  output logic        blank
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Value loaded into the hold counter on grant. The hold lasts exactly
  // HOLD_CYCLES cycles because the switch edge is the one where hcnt == 0.
  localparam logic [15:0] c_HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_hcnt,  w_hcnt_nxt;
  logic [1:0]  r_last,  w_last_nxt;
  logic [2:0]  r_grant, w_grant_nxt;
  logic [15:0] r_data,  w_data_nxt;
  logic        r_blank, w_blank_nxt;

  logic        w_own_req;
  logic [2:0]  w_others;
  logic [1:0]  w_win_any;
  logic [1:0]  w_win_oth;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] x);
    return 3'b001 << x;
  endfunction

  // Return the first set bit of r, searching last+1, last+2, last+3 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c;
    logic       found;
    rr_pick = last;
    c       = last;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c = inc3(c);
      if (r[c] && !found) begin
        rr_pick = c;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [15:0] sel_data(input logic [1:0] idx,
                                           input logic [15:0] d0,
                                           input logic [15:0] d1,
                                           input logic [15:0] d2);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  // In OWN, r_last always points at the current owner.
  assign w_own_req = req[r_last];
  assign w_others  = req & ~onehot3(r_last);
  assign w_win_any = rr_pick(req, r_last);
  // The owner is masked out of w_others, so the search can only land on
  // one of the other two requesters.
  assign w_win_oth = rr_pick(w_others, r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hcnt  <= 16'd0;
      r_last  <= 2'd2;
      r_grant <= 3'b000;
      r_data  <= 16'h0000;
      r_blank <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_data  <= w_data_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_data_nxt  = r_data;
    w_blank_nxt = r_blank;

    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = 3'b000;
        w_blank_nxt = 1'b1;
        if (req != 3'b000) begin
          w_state_nxt = ST_OWN;
          w_last_nxt  = w_win_any;
          w_grant_nxt = onehot3(w_win_any);
          w_blank_nxt = 1'b0;
          w_data_nxt  = sel_data(w_win_any, data0, data1, data2);
          w_hcnt_nxt  = c_HOLD_LOAD;
        end
      end

      ST_OWN: begin
        if (r_hcnt != 16'd0) begin
          w_hcnt_nxt = r_hcnt - 16'd1;
          if (w_own_req) begin
            w_data_nxt = sel_data(r_last, data0, data1, data2);
          end
        end else if (w_others != 3'b000) begin
          // Hand the display directly to the next owner. grant never passes
          // through zero and blank stays low.
          w_last_nxt  = w_win_oth;
          w_grant_nxt = onehot3(w_win_oth);
          w_blank_nxt = 1'b0;
          w_data_nxt  = sel_data(w_win_oth, data0, data1, data2);
          w_hcnt_nxt  = c_HOLD_LOAD;
        end else if (w_own_req) begin
          w_data_nxt = sel_data(r_last, data0, data1, data2);
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 3'b000;
          w_blank_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 3'b000;
        w_blank_nxt = 1'b1;
      end
    endcase
  end

  assign grant    = r_grant;
  assign data_out = r_data;
  assign blank    = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_arbiter
// Description : Self-checking bench for disp_arbiter. It applies a table of
//               per-cycle vectors to a HOLD_CYCLES=4 instance and runs a short
//               hand-written sequence on a HOLD_CYCLES=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_arbiter;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  g;
    logic [15:0] dout;
    logic        b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req4, req1;
  logic [15:0] data0, data1, data2;
  logic [2:0]  grant4, grant1;
  logic [15:0] dout4, dout1;
  logic        blank4, blank1;

  int checks = 0;
  int errors = 0;

  vec_t tv[39];

  always #5 clk = ~clk;

  disp_arbiter #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant4), .data_out(dout4), .blank(blank4)
  );

  disp_arbiter #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant1), .data_out(dout1), .blank(blank1)
  );

  function automatic vec_t mk(input logic r, input logic [2:0] q,
                              input logic [15:0] a, input logic [15:0] bb,
                              input logic [15:0] c, input logic [2:0] g,
                              input logic [15:0] d, input logic bl);
    vec_t v;
    v.rst = r; v.req = q; v.d0 = a; v.d1 = bb; v.d2 = c;
    v.g = g; v.dout = d; v.b = bl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inv(input string name, input logic [2:0] g, input logic b);
    checks++;
    if (!$onehot0(g) || (b !== (g == 3'b000))) begin
      errors++;
      $display("FAIL %s: grant %b blank %b violates owner/blank invariant", name, g, b);
    end
  endtask

  initial begin
    // Reset, first grant, then the owner drops its request: grant and the
    // data value are held for 4 cycles total before the display is released.
    tv[0] = mk(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 1);
    tv[1] = mk(0, 3'b001, 16'h1234, 16'h0000, 16'h0000, 3'b001, 16'h1234, 0);
    tv[2] = mk(0, 3'b001, 16'h5678, 16'h0000, 16'h0000, 3'b001, 16'h5678, 0);
    tv[3] = mk(0, 3'b000, 16'h9999, 16'h0000, 16'h0000, 3'b001, 16'h5678, 0);
    tv[4] = mk(0, 3'b000, 16'h9999, 16'h0000, 16'h0000, 3'b001, 16'h5678, 0);
    tv[5] = mk(0, 3'b000, 16'h9999, 16'h0000, 16'h0000, 3'b000, 16'h5678, 1);
    tv[6] = mk(0, 3'b000, 16'h9999, 16'h0000, 16'h0000, 3'b000, 16'h5678, 1);
    // All three requesting: last=0, so ownership rotates 1,2,0,1 with 4
    // cycles per owner.
    for (int i = 0; i < 4; i++) begin
      tv[7 + i]  = mk(0, 3'b111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'b010, 16'hBBBB, 0);
      tv[11 + i] = mk(0, 3'b111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'b100, 16'hCCCC, 0);
      tv[15 + i] = mk(0, 3'b111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'b001, 16'hAAAA, 0);
    end
    tv[19] = mk(0, 3'b111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'b010, 16'hBBBB, 0);
    // Owner 1 alone for 10 cycles. Its data change is followed one cycle
    // later, then req0 rises and takes over immediately because hcnt is 0.
    for (int i = 0; i < 5; i++) begin
      tv[20 + i] = mk(0, 3'b010, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'b010, 16'hBBBB, 0);
      tv[25 + i] = mk(0, 3'b010, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b010, 16'hBEEF, 0);
    end
    tv[30] = mk(0, 3'b011, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b001, 16'hAAAA, 0);
    // Requester 2 waits out the hold, takes over, and is then reset mid-hold.
    // After reset, requester 0 wins over requester 2.
    tv[31] = mk(0, 3'b100, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b001, 16'hAAAA, 0);
    tv[32] = mk(0, 3'b100, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b001, 16'hAAAA, 0);
    tv[33] = mk(0, 3'b100, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b001, 16'hAAAA, 0);
    tv[34] = mk(0, 3'b100, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b100, 16'hCCCC, 0);
    tv[35] = mk(0, 3'b100, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b100, 16'hCCCC, 0);
    tv[36] = mk(1, 3'b100, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b000, 16'h0000, 1);
    tv[37] = mk(0, 3'b101, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b001, 16'hAAAA, 0);
    tv[38] = mk(0, 3'b000, 16'hAAAA, 16'hBEEF, 16'hCCCC, 3'b001, 16'hAAAA, 0);

    req1 = 3'b000;
    for (int i = 0; i < 39; i++) begin
      rst   = tv[i].rst;
      req4  = tv[i].req;
      data0 = tv[i].d0;
      data1 = tv[i].d1;
      data2 = tv[i].d2;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d grant", i), {13'd0, grant4}, {13'd0, tv[i].g});
      chk($sformatf("vec%0d data_out", i), dout4, tv[i].dout);
      chk($sformatf("vec%0d blank", i), {15'd0, blank4}, {15'd0, tv[i].b});
      chk_inv($sformatf("vec%0d invariant", i), grant4, blank4);
    end

    // HOLD_CYCLES=1 with two requesters: ownership alternates every cycle.
    // The most recent reset left last=2, so requester 0 wins first.
    req4  = 3'b000;
    data0 = 16'h1111;
    data1 = 16'h2222;
    req1  = 3'b011;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold1 cyc%0d grant", k), {13'd0, grant1},
          (k % 2 == 0) ? 16'h0001 : 16'h0002);
      chk($sformatf("hold1 cyc%0d data_out", k), dout1,
          (k % 2 == 0) ? 16'h1111 : 16'h2222);
      chk_inv($sformatf("hold1 cyc%0d invariant", k), grant1, blank1);
    end
    // Requester 1 owns the display now. With no requests left and hcnt=0,
    // the display is released on the next edge.
    req1 = 3'b000;
    @(posedge clk);
    #1;
    chk("hold1 release grant", {13'd0, grant1}, 16'h0000);
    chk("hold1 release blank", {15'd0, blank1}, 16'h0001);
    chk("hold1 release data_out", dout1, 16'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
